// File: rtl/imm_pkg.sv
// Immediate format codes shared by the extender, control decoder and encoder,
// plus a helper that tests whether a value sign-extends from a given bit.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  localparam int unsigned INSTR_STEP = 4;

  // True when v[31:msb] are all equal, i.e. v fits in a (msb+1)-bit signed field.
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> msb);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request and instruction-memory write beat bundle for imm_encoder.
// slave is the encoder's view, master the loader / memory side.
interface imm_encoder_if #(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned ERRCNTWIDTH = 8
);
  logic                   Valid_i;
  logic                   Ready_o;
  logic [2:0]             ImmSrc_i;
  logic [DATAWIDTH-1:0]   Imm_i;
  logic [DATAWIDTH-1:0]   Base_i;
  logic                   AddrLoad_i;
  logic [ADDRWIDTH-1:0]   AddrInit_i;
  logic                   Valid_o;
  logic                   Ready_i;
  logic [DATAWIDTH-1:0]   Instr_o;
  logic [ADDRWIDTH-1:0]   Addr_o;
  logic                   Err_o;
  logic [ERRCNTWIDTH-1:0] ErrCount_o;

  modport slave (
    input  Valid_i, ImmSrc_i, Imm_i, Base_i, AddrLoad_i, AddrInit_i, Ready_i,
    output Ready_o, Valid_o, Instr_o, Addr_o, Err_o, ErrCount_o
  );

  modport master (
    output Valid_i, ImmSrc_i, Imm_i, Base_i, AddrLoad_i, AddrInit_i, Ready_i,
    input  Ready_o, Valid_o, Instr_o, Addr_o, Err_o, ErrCount_o
  );
endinterface

// File: rtl/imm_pack.sv
// Scatters an immediate into the RISC-V field positions of a base instruction.
// Unrepresentable immediates or unknown formats return base unchanged with err set.
module imm_pack
  import imm_pkg::*;
(
  input  logic [2:0]  src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = base;
    err   = 1'b0;
    case (imm_src_e'(src))
      IMM_I: begin
        err          = !sext_ok(imm, 11);
        instr[31:20] = imm[11:0];
      end
      IMM_S: begin
        err          = !sext_ok(imm, 11);
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
      end
      IMM_B: begin
        err          = !sext_ok(imm, 12) || imm[0];
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
      end
      IMM_U: begin
        err          = (imm[11:0] != '0);
        instr[31:12] = imm[31:12];
      end
      IMM_J: begin
        err          = !sext_ok(imm, 20) || imm[0];
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
      end
      default: err = 1'b1;
    endcase
    if (err) instr = base;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder: stage 1 holds the request, stage 2 holds the
// packed instruction beat with its instruction-memory write address.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned ERRCNTWIDTH = 8
) (
  input logic       clk_i,
  input logic       rst_n_i,
  imm_encoder_if.slave bus
);

  logic                   s1_valid;
  logic [2:0]             s1_src;
  logic [DATAWIDTH-1:0]   s1_imm;
  logic [DATAWIDTH-1:0]   s1_base;
  logic                   s2_valid;
  logic                   s2_err;
  logic [DATAWIDTH-1:0]   s2_instr;
  logic [ADDRWIDTH-1:0]   s2_addr;
  logic [ADDRWIDTH-1:0]   addr;
  logic [ERRCNTWIDTH-1:0] errcnt;
  logic [DATAWIDTH-1:0]   pk_instr;
  logic                   pk_err;
  logic                   s2_free;
  logic                   s1_free;
  logic                   s1_adv;

  imm_pack u_pack (
    .src   (s1_src),
    .imm   (s1_imm),
    .base  (s1_base),
    .instr (pk_instr),
    .err   (pk_err)
  );

  assign s2_free = !s2_valid || bus.Ready_i;
  assign s1_free = !s1_valid || s2_free;
  assign s1_adv  = s1_valid && s2_free;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_instr <= '0;
      s2_addr  <= '0;
      addr     <= '0;
      errcnt   <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= bus.Valid_i;
        if (bus.Valid_i) begin
          s1_src  <= bus.ImmSrc_i;
          s1_imm  <= bus.Imm_i;
          s1_base <= bus.Base_i;
        end
      end
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= pk_instr;
          s2_err   <= pk_err;
          s2_addr  <= addr;
        end
      end
      // A load in the same cycle as a transfer overrides the +4; the
      // transferring beat has already sampled the pre-load address above.
      if (bus.AddrLoad_i)
        addr <= bus.AddrInit_i;
      else if (s1_adv && !pk_err)
        addr <= addr + ADDRWIDTH'(INSTR_STEP);
      if (s2_valid && bus.Ready_i && s2_err && (errcnt != '1))
        errcnt <= errcnt + 1'b1;
    end
  end

  assign bus.Ready_o    = s1_free;
  assign bus.Valid_o    = s2_valid;
  assign bus.Instr_o    = s2_instr;
  assign bus.Addr_o     = s2_addr;
  assign bus.Err_o      = s2_err;
  assign bus.ErrCount_o = errcnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a table-driven field model predicts each
// beat, a negedge monitor pops and compares on every output handshake.
module tb_imm_encoder;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if #(.DATAWIDTH(32), .ADDRWIDTH(32), .ERRCNTWIDTH(8)) bus ();

  imm_encoder #(.DATAWIDTH(32), .ADDRWIDTH(32), .ERRCNTWIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] addr;
    logic [31:0] imm;
    logic [2:0]  src;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_addr = '0;
  int unsigned m_errcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Representability expressed as signed ranges and alignment.
  function automatic bit ref_rep(input logic [2:0] src, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (src)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd3:       return (imm % 4096) == 0;
      3'd4:       return (v >= -(64'sd1 <<< 20)) && (v <= (64'sd1 <<< 20) - 2) && (v % 2 == 0);
      default:    return 1'b0;
    endcase
  endfunction

  // Field map: segment k copies imm[ilo+j] to instr[lo+j] for j in 0..hi-lo.
  function automatic logic [31:0] ref_pack(input logic [2:0] src, input logic [31:0] imm,
                                           input logic [31:0] base);
    int lo[4], hi[4], ilo[4];
    int n;
    logic [31:0] r;
    r = base;
    n = 0;
    case (src)
      3'd0: begin lo = '{20, 0, 0, 0}; hi = '{31, 0, 0, 0}; ilo = '{0, 0, 0, 0};   n = 1; end
      3'd1: begin lo = '{25, 7, 0, 0}; hi = '{31, 11, 0, 0}; ilo = '{5, 0, 0, 0};  n = 2; end
      3'd2: begin lo = '{31, 7, 25, 8}; hi = '{31, 7, 30, 11}; ilo = '{12, 11, 5, 1}; n = 4; end
      3'd3: begin lo = '{12, 0, 0, 0}; hi = '{31, 0, 0, 0}; ilo = '{12, 0, 0, 0};  n = 1; end
      3'd4: begin lo = '{31, 21, 20, 12}; hi = '{31, 30, 20, 19}; ilo = '{20, 1, 11, 12}; n = 4; end
      default: begin lo = '{0, 0, 0, 0}; hi = '{0, 0, 0, 0}; ilo = '{0, 0, 0, 0}; n = 0; end
    endcase
    if (!ref_rep(src, imm)) return base;
    for (int s = 0; s < n; s++)
      for (int b = lo[s]; b <= hi[s]; b++)
        r[b] = imm[ilo[s] + b - lo[s]];
    return r;
  endfunction

  // Decode-side sign extender, used to confirm pack-then-extend round-trips.
  function automatic logic [31:0] ref_ext(input logic [2:0] src, input logic [31:0] i);
    case (src)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
    exp_t e;
    bit acc;
    int unsigned waited;
    acc = 1'b0;
    waited = 0;
    bus.Valid_i  = 1'b1;
    bus.ImmSrc_i = src;
    bus.Imm_i    = imm;
    bus.Base_i   = base;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus.Ready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.Valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: Ready_o stayed 0, expected 1 within 200 cycles");
    end else begin
      e.src   = src;
      e.imm   = imm;
      e.err   = !ref_rep(src, imm);
      e.instr = ref_pack(src, imm, base);
      e.addr  = m_addr;
      if (!e.err) m_addr = m_addr + 32'd4;
      sbq.push_back(e);
    end
  endtask

  task automatic load(input logic [31:0] a);
    bus.AddrLoad_i = 1'b1;
    bus.AddrInit_i = a;
    @(posedge clk);
    #1;
    bus.AddrLoad_i = 1'b0;
    m_addr = a;
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, and hold-stability under backpressure.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr, prev_addr;
  logic        prev_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.Valid_o), 32'd1);
        check("hold_instr", bus.Instr_o, prev_instr);
        check("hold_addr", bus.Addr_o, prev_addr);
        check("hold_err", 32'(bus.Err_o), 32'(prev_err));
      end
      if (bus.Valid_o && bus.Ready_i) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got instr 0x%08h, expected no beat", bus.Instr_o);
        end else begin
          mon_e = sbq.pop_front();
          check("instr", bus.Instr_o, mon_e.instr);
          check("err", 32'(bus.Err_o), 32'(mon_e.err));
          check("addr", bus.Addr_o, mon_e.addr);
          check("errcount", 32'(bus.ErrCount_o), m_errcnt);
          if (!mon_e.err) check("roundtrip", ref_ext(mon_e.src, bus.Instr_o), mon_e.imm);
          if (mon_e.err && m_errcnt < 255) m_errcnt++;
        end
      end
      prev_stall = bus.Valid_o && !bus.Ready_i;
      prev_instr = bus.Instr_o;
      prev_addr  = bus.Addr_o;
      prev_err   = bus.Err_o;
    end
  end

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      2: return $urandom() & 32'hFFFF_F000;
      default: return (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & ~32'($urandom_range(0, 1));
    endcase
  endfunction

  bit done;

  initial begin
    bus.Valid_i    = 1'b0;
    bus.ImmSrc_i   = '0;
    bus.Imm_i      = '0;
    bus.Base_i     = '0;
    bus.AddrLoad_i = 1'b0;
    bus.AddrInit_i = '0;
    bus.Ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(bus.Valid_o), 32'd0);
    check("rst_err", 32'(bus.Err_o), 32'd0);
    check("rst_instr", bus.Instr_o, 32'd0);
    check("rst_addr", bus.Addr_o, 32'd0);
    check("rst_errcount", 32'(bus.ErrCount_o), 32'd0);
    check("rst_ready", 32'(bus.Ready_o), 32'd1);
    @(posedge clk);
    #1;

    // I-type with two-cycle latency
    load(32'h100);
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0093);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(bus.Valid_o), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(bus.Valid_o), 32'd1);
    check("lat_cycle2_instr", bus.Instr_o, 32'hFFF0_0093);
    check("lat_cycle2_addr", bus.Addr_o, 32'h100);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back S, B, U, J
    load(32'h100);
    send(3'd1, 32'd8, 32'h0020_A023);
    send(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
    send(3'd3, 32'h1234_5000, 32'h0000_02B7);
    send(3'd4, 32'h0000_0800, 32'h0000_00EF);
    drain();

    // Error beats keep the address; a good beat reuses it
    send(3'd0, 32'h800, 32'h0000_0013);
    send(3'd2, 32'h5, 32'h0000_0063);
    send(3'd0, 32'h4, 32'h0000_0013);
    send(3'd7, 32'h0, 32'h0000_0033);
    drain();
    check("errcount_3", 32'(bus.ErrCount_o), 32'd3);

    // Backpressure: 4 stalled cycles while offering 3 beats
    bus.Ready_i = 1'b0;
    fork
      begin
        send(3'd0, 32'd1, 32'h0000_0093);
        send(3'd0, 32'd2, 32'h0000_0093);
        send(3'd0, 32'd3, 32'h0000_0093);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_ready_low", 32'(bus.Ready_o), 32'd0);
        @(posedge clk);
        #1 bus.Ready_i = 1'b1;
      end
    join
    drain();

    // Load coinciding with a stage transfer
    send(3'd0, 32'd5, 32'h0000_0093);
    bus.AddrLoad_i = 1'b1;
    bus.AddrInit_i = 32'h300;
    m_addr = 32'h300;
    send(3'd0, 32'd6, 32'h0000_0093);
    bus.AddrLoad_i = 1'b0;
    send(3'd0, 32'd7, 32'h0000_0093);
    drain();

    // Address wrap
    load(32'hFFFF_FFFC);
    send(3'd3, 32'h0000_1000, 32'h0000_0037);
    send(3'd3, 32'h0000_2000, 32'h0000_0037);
    drain();

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++)
          send(3'($urandom_range(0, 7)), rand_imm(), $urandom());
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.Ready_i = ($urandom_range(0, 3) != 0);
        end
        bus.Ready_i = 1'b1;
      end
    join
    drain();

    // Error counter saturation
    for (int k = 0; k < 260; k++)
      send(3'($urandom_range(5, 7)), $urandom(), $urandom());
    drain();
    check("errcount_sat", 32'(bus.ErrCount_o), 32'hFF);

    // Reset with both stages full
    bus.Ready_i = 1'b0;
    send(3'd0, 32'd9, 32'h0000_0093);
    send(3'd0, 32'd10, 32'h0000_0093);
    @(negedge clk);
    check("full_ready_low", 32'(bus.Ready_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sbq.delete();
    m_addr = '0;
    m_errcnt = 0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.Valid_o), 32'd0);
    check("mid_rst_errcount", 32'(bus.ErrCount_o), 32'd0);
    check("mid_rst_addr", bus.Addr_o, 32'd0);
    check("mid_rst_ready", 32'(bus.Ready_o), 32'd1);
    @(posedge clk);
    #1 bus.Ready_i = 1'b1;
    send(3'd0, 32'd11, 32'h0000_0093);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
